// File: rtl/upc_loop_monitor_pkg.sv
// ----------------------------------------------------------------------------
// upc_mon_pkg
//   Shared types for the HLS loop performance monitor.
//   - mod_state_e  : module handshake tracker states
//   - loop_state_e : loop invocation tracker states
//   - CNT_W_DEFAULT: default width of every statistics counter
// ----------------------------------------------------------------------------
package upc_mon_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        WAIT_CONT = 2'd2
    } mod_state_e;

    typedef enum logic {
        L_IDLE = 1'b0,
        L_RUN  = 1'b1
    } loop_state_e;

endpackage

// File: rtl/upc_loop_monitor_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Event counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clock  in   rising-edge clock
//     reset  in   asynchronous active-low clear
//     inc    in   count one event this cycle
//     hold   in   freeze the current value (overrides inc)
//     count  out  registered count, CNT_W bits
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && !hold && !(&count)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/upc_loop_monitor.sv
// ----------------------------------------------------------------------------
// upc_loop_monitor
//   Passive performance monitor for one HLS module and one pipelined loop
//   inside it. Tracks the ap_* handshake and the loop FSM/stage signals and
//   keeps saturating transaction, busy, iteration and stall counters.
//   Ports:
//     clock, reset (async, active-low)
//     ap_start/ap_ready/ap_done/ap_continue   module handshake
//     cur_state, iter_*_state, quit_state      loop FSM state and constants
//     iter_*_block/enable, quit_block/enable   stage stall flags / enables
//     loop_start/ready/done/continue           loop handshake
//     quit_at_end                              quit needs an iteration end
//     finish                                   sticky freeze request
//     mod_txn_cnt, mod_busy_cnt, loop_iter_cnt, loop_end_cnt,
//     loop_stall_cnt, loop_txn_cnt             CNT_W counters
//     mod_busy, loop_active, frozen            status flags
// ----------------------------------------------------------------------------
module upc_loop_monitor
    import upc_mon_pkg::*;
#(
    parameter int STATE_W = 1,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    input  logic               finish,
    output logic [CNT_W-1:0]   mod_txn_cnt,
    output logic [CNT_W-1:0]   mod_busy_cnt,
    output logic [CNT_W-1:0]   loop_iter_cnt,
    output logic [CNT_W-1:0]   loop_end_cnt,
    output logic [CNT_W-1:0]   loop_stall_cnt,
    output logic [CNT_W-1:0]   loop_txn_cnt,
    output logic               mod_busy,
    output logic               loop_active,
    output logic               frozen
);

    mod_state_e  mod_state;
    loop_state_e loop_state;

    logic istart, iend, quit;
    logic at_start_state;
    logic loop_run;
    logic mod_txn_inc, mod_busy_inc;
    logic iter_inc, end_inc, stall_inc, loop_txn_inc;

    // Stage fire terms: a stage fires when the FSM is in its state, the
    // stage is enabled and it is not stalled this cycle.
    assign at_start_state = (cur_state == iter_start_state);
    assign istart = at_start_state & iter_start_enable & ~iter_start_block;
    assign iend   = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
    // Loop exit condition; a quit without a following loop_done is legal,
    // so it does not drive the loop tracker and no counter is defined for it.
    assign quit   = (cur_state == quit_state) & quit_enable & ~quit_block
                  & (~quit_at_end | iend);

    // A transaction completes either on the BUSY exit or when start and done
    // coincide in IDLE (zero-latency call that never enters BUSY).
    assign mod_txn_inc  = ap_done & ((mod_state == BUSY) | ((mod_state == IDLE) & ap_start));
    assign mod_busy_inc = (mod_state == BUSY);

    // Iteration activity only counts while a loop invocation is open.
    assign loop_run     = (loop_state == L_RUN);
    assign iter_inc     = loop_run & istart;
    assign end_inc      = loop_run & iend;
    assign stall_inc    = loop_run & iter_start_block & at_start_state;
    assign loop_txn_inc = loop_run & loop_done & loop_continue;

    // frozen is sampled as the hold for this cycle, so an event arriving with
    // finish is still counted and the freeze takes effect one cycle later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frozen <= 1'b0;
        end else if (finish) begin
            frozen <= 1'b1;
        end
    end

    // Module handshake tracker
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mod_state <= IDLE;
            mod_busy  <= 1'b0;
        end else if (!frozen) begin
            case (mod_state)
                IDLE: begin
                    if (ap_start && !ap_done) begin
                        mod_state <= BUSY;
                        mod_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (ap_done) begin
                        mod_state <= ap_continue ? IDLE : WAIT_CONT;
                        mod_busy  <= 1'b0;
                    end
                end
                WAIT_CONT: begin
                    if (ap_continue) begin
                        mod_state <= IDLE;
                    end
                end
                default: begin
                    mod_state <= IDLE;
                    mod_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Loop invocation tracker
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            loop_state  <= L_IDLE;
            loop_active <= 1'b0;
        end else if (!frozen) begin
            case (loop_state)
                L_IDLE: begin
                    if (loop_start) begin
                        loop_state  <= L_RUN;
                        loop_active <= 1'b1;
                    end
                end
                L_RUN: begin
                    if (loop_done && loop_continue) begin
                        loop_state  <= L_IDLE;
                        loop_active <= 1'b0;
                    end
                end
                default: begin
                    loop_state  <= L_IDLE;
                    loop_active <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_mod_txn (
        .clock(clock), .reset(reset), .inc(mod_txn_inc),  .hold(frozen), .count(mod_txn_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_mod_busy (
        .clock(clock), .reset(reset), .inc(mod_busy_inc), .hold(frozen), .count(mod_busy_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_loop_iter (
        .clock(clock), .reset(reset), .inc(iter_inc),     .hold(frozen), .count(loop_iter_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_loop_end (
        .clock(clock), .reset(reset), .inc(end_inc),      .hold(frozen), .count(loop_end_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_loop_stall (
        .clock(clock), .reset(reset), .inc(stall_inc),    .hold(frozen), .count(loop_stall_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_loop_txn (
        .clock(clock), .reset(reset), .inc(loop_txn_inc), .hold(frozen), .count(loop_txn_cnt)
    );

endmodule

// File: tb/tb_upc_loop_monitor.sv
// ----------------------------------------------------------------------------
// tb_upc_loop_monitor
//   Directed stimulus for upc_loop_monitor plus a narrow standalone
//   sat_counter. Expected snapshots are queued by the stimulus thread and
//   compared against the DUT by a separate monitor on the falling edge.
// ----------------------------------------------------------------------------
module tb_upc_loop_monitor;

    localparam int STATE_W = 1;
    localparam int CNT_W   = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0;
    logic [STATE_W-1:0] cur_state = '0;
    logic [STATE_W-1:0] iter_start_state = '0, iter_end_state = '0, quit_state = '0;
    logic iter_start_block = 1'b0, iter_end_block = 1'b0, quit_block = 1'b0;
    logic iter_start_enable = 1'b0, iter_end_enable = 1'b0, quit_enable = 1'b0;
    logic loop_start = 1'b0, loop_ready = 1'b0, loop_done = 1'b0, loop_continue = 1'b0;
    logic quit_at_end = 1'b1;
    logic finish = 1'b0;

    logic [CNT_W-1:0] mod_txn_cnt, mod_busy_cnt, loop_iter_cnt, loop_end_cnt;
    logic [CNT_W-1:0] loop_stall_cnt, loop_txn_cnt;
    logic mod_busy, loop_active, frozen;

    logic       sat_inc = 1'b0, sat_hold = 1'b0;
    logic [2:0] sat_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] txn, busy, iter, endc, stall, ltxn;
        logic        mb, la, fr;
        logic [2:0]  sat;
    } snap_t;

    snap_t exp_q[$];

    always #5 clock = ~clock;

    upc_loop_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .cur_state(cur_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
        .quit_block(quit_block), .iter_start_enable(iter_start_enable),
        .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end), .finish(finish),
        .mod_txn_cnt(mod_txn_cnt), .mod_busy_cnt(mod_busy_cnt),
        .loop_iter_cnt(loop_iter_cnt), .loop_end_cnt(loop_end_cnt),
        .loop_stall_cnt(loop_stall_cnt), .loop_txn_cnt(loop_txn_cnt),
        .mod_busy(mod_busy), .loop_active(loop_active), .frozen(frozen)
    );

    sat_counter #(.CNT_W(3)) u_sat (
        .clock(clock), .reset(reset), .inc(sat_inc), .hold(sat_hold), .count(sat_count)
    );

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
        end
    endtask

    // Monitor: consume every queued expectation at the next falling edge.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front();
            cmp(e.name, "mod_txn_cnt",    mod_txn_cnt,    e.txn);
            cmp(e.name, "mod_busy_cnt",   mod_busy_cnt,   e.busy);
            cmp(e.name, "loop_iter_cnt",  loop_iter_cnt,  e.iter);
            cmp(e.name, "loop_end_cnt",   loop_end_cnt,   e.endc);
            cmp(e.name, "loop_stall_cnt", loop_stall_cnt, e.stall);
            cmp(e.name, "loop_txn_cnt",   loop_txn_cnt,   e.ltxn);
            cmp(e.name, "mod_busy",       {31'd0, mod_busy},    {31'd0, e.mb});
            cmp(e.name, "loop_active",    {31'd0, loop_active}, {31'd0, e.la});
            cmp(e.name, "frozen",         {31'd0, frozen},      {31'd0, e.fr});
            cmp(e.name, "sat_count",      {29'd0, sat_count},   {29'd0, e.sat});
        end
    end

    task automatic expect_snap(input string nm,
                               input int txn, input int busy, input int iter,
                               input int endc, input int stall, input int ltxn,
                               input logic mb, input logic la, input logic fr,
                               input int sat);
        snap_t e;
        e.name = nm;
        e.txn = txn;   e.busy = busy;   e.iter = iter;
        e.endc = endc; e.stall = stall; e.ltxn = ltxn;
        e.mb = mb; e.la = la; e.fr = fr;
        e.sat = sat[2:0];
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        // Reset state
        step(2);
        reset = 1'b1;
        expect_snap("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1);

        // Narrow saturating counter: 10 increments with a 2-cycle hold -> 7
        sat_inc = 1'b1;
        step(4);
        expect_snap("sat_4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        sat_hold = 1'b1;
        step(2);
        expect_snap("sat_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        sat_hold = 1'b0;
        step(6);
        sat_inc = 1'b0;
        expect_snap("sat_top", 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        step(1);

        // Single transaction, 10 BUSY cycles
        ap_start = 1'b1;
        step(1);
        ap_start = 1'b0;
        expect_snap("txn1_busy", 0, 0, 0, 0, 0, 0, 1, 0, 0, 7);
        step(9);
        ap_done = 1'b1; ap_continue = 1'b1;
        step(1);
        ap_done = 1'b0; ap_continue = 1'b0;
        expect_snap("txn1_done", 1, 10, 0, 0, 0, 0, 0, 0, 0, 7);

        // Done without continue -> WAIT_CONT, start ignored until continue
        ap_start = 1'b1;
        step(1);
        ap_start = 1'b0; ap_done = 1'b1;
        step(1);
        ap_done = 1'b0; ap_start = 1'b1;
        expect_snap("wait_enter", 2, 11, 0, 0, 0, 0, 0, 0, 0, 7);
        step(3);
        ap_start = 1'b0;
        expect_snap("wait_hold", 2, 11, 0, 0, 0, 0, 0, 0, 0, 7);
        ap_continue = 1'b1;
        step(1);
        ap_continue = 1'b0;
        ap_start = 1'b1;
        step(1);
        ap_start = 1'b0;
        expect_snap("after_cont", 2, 11, 0, 0, 0, 0, 1, 0, 0, 7);
        ap_done = 1'b1; ap_continue = 1'b1;
        step(1);
        ap_start = 1'b1;
        expect_snap("txn3", 3, 12, 0, 0, 0, 0, 0, 0, 0, 7);
        // start & done together in IDLE: counted, FSM stays IDLE
        step(1);
        ap_start = 1'b0; ap_done = 1'b0; ap_continue = 1'b0;
        expect_snap("start_done_idle", 4, 12, 0, 0, 0, 0, 0, 0, 0, 7);

        // Loop run: 784 starts, 16-cycle pipeline, 784 ends
        loop_start = 1'b1;
        step(1);
        loop_start = 1'b0;
        expect_snap("loop_open", 4, 12, 0, 0, 0, 0, 0, 1, 0, 7);
        for (int i = 0; i < 800; i++) begin
            iter_start_enable = (i < 784);
            iter_end_enable   = (i >= 16);
            step(1);
        end
        iter_start_enable = 1'b0; iter_end_enable = 1'b0;
        expect_snap("loop_iters", 4, 12, 784, 784, 0, 0, 0, 1, 0, 7);
        loop_done = 1'b1; loop_continue = 1'b1;
        step(1);
        loop_done = 1'b0; loop_continue = 1'b0;
        expect_snap("loop_close", 4, 12, 784, 784, 0, 1, 0, 0, 0, 7);

        // Stall: 5 blocked cycles add no iterations
        loop_start = 1'b1;
        step(1);
        loop_start = 1'b0;
        iter_start_enable = 1'b1;
        step(3);
        iter_start_block = 1'b1;
        step(5);
        iter_start_block = 1'b0;
        expect_snap("stall", 4, 12, 787, 784, 5, 1, 0, 1, 0, 7);
        step(2);
        expect_snap("post_stall", 4, 12, 789, 784, 5, 1, 0, 1, 0, 7);

        // Freeze: the finish-cycle istart still counts, then nothing moves
        finish = 1'b1;
        step(1);
        finish = 1'b0;
        expect_snap("freeze_edge", 4, 12, 790, 784, 5, 1, 0, 1, 1, 7);
        iter_end_enable = 1'b1;
        ap_start = 1'b1;
        loop_done = 1'b1; loop_continue = 1'b1;
        step(20);
        expect_snap("frozen_hold", 4, 12, 790, 784, 5, 1, 0, 1, 1, 7);
        iter_start_enable = 1'b0; iter_end_enable = 1'b0;
        ap_start = 1'b0; loop_done = 1'b0; loop_continue = 1'b0;
        step(1);

        // Mid-cycle reset clears everything, including frozen
        reset = 1'b0;
        #1;
        expect_snap("reset_frozen", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        reset = 1'b1;
        ap_start = 1'b1;
        step(1);
        ap_start = 1'b0; loop_start = 1'b1;
        step(1);
        loop_start = 1'b0; iter_start_enable = 1'b1;
        step(2);
        iter_start_enable = 1'b0;
        expect_snap("busy_run", 0, 3, 2, 0, 0, 0, 1, 1, 0, 0);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        expect_snap("reset_busy_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        reset = 1'b1;
        ap_start = 1'b1;
        step(1);
        ap_start = 1'b0; ap_done = 1'b1; ap_continue = 1'b1;
        step(1);
        ap_done = 1'b0; ap_continue = 1'b0;
        expect_snap("clean_txn", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Drain the scoreboard with a bounded wait
        begin
            int budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                step(1);
                budget--;
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain pending=%0d required=0", exp_q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
